// File: rtl/updi_uart_tx_if.sv
// updi_uart_tx_if: TX FIFO read handshake between the FIFO (slave) and the UPDI serializer (master)
interface updi_uart_tx_if;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en;
  modport master (input fifo_data, input fifo_empty, output fifo_rd_en);
  modport slave (output fifo_data, output fifo_empty, input fifo_rd_en);
endinterface

// File: rtl/updi_uart_tx.sv
// updi_uart_tx: UPDI frame serializer (start, 8N LSB-first, even parity, 2 stop); UPDI_TX_IDLE_GAP_EN adds a released guard gap
module updi_uart_tx #(
  parameter int UART_CLK_DIV  = 10,
  parameter int IDLE_GAP_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_enable,
  updi_uart_tx_if.master fifo,
  output logic tx_out,
  output logic tx_oe,
  output logic busy,
  output logic frame_done
);
  localparam int CW = $clog2(UART_CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(UART_CLK_DIV - 1);
  if (UART_CLK_DIV < 2 || IDLE_GAP_BITS < 1 || IDLE_GAP_BITS > 15) begin : g_bad_cfg
    $error("updi_uart_tx: illegal UART_CLK_DIV or IDLE_GAP_BITS");
  end
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UPDI_TX_IDLE_GAP_EN
    , GAP
`endif
  } state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q;
  logic [7:0] sh_q;
  logic par_q, tx_out_q, tx_oe_q, tick, pop;
`ifdef UPDI_TX_IDLE_GAP_EN
  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP_BITS - 1);
  logic [3:0] gap_q;
`endif
  // bit-time tick, pop decision and frame-end decode from registered state
  always_comb begin
    tick = cnt_q == CNT_LAST;
    pop = state_q == IDLE && tx_enable && !fifo.fifo_empty && !rst;
    cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
`ifdef UPDI_TX_IDLE_GAP_EN
    frame_done = tick && state_q == GAP && gap_q == GAP_LAST;
`else
    frame_done = tick && state_q == STOP && idx_q == 3'd1;
`endif
  end
  assign fifo.fifo_rd_en = pop;
  assign busy = state_q != IDLE || pop;
  assign tx_out = tx_out_q;
  assign tx_oe = tx_oe_q;
  // frame sequencer; line outputs are registered one cycle ahead of the bit they show
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      tx_out_q <= 1'b1;
      tx_oe_q <= 1'b0;
`ifdef UPDI_TX_IDLE_GAP_EN
      gap_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: if (pop) begin
          sh_q <= fifo.fifo_data;
          par_q <= ^fifo.fifo_data;
          state_q <= START;
          tx_out_q <= 1'b0;
          tx_oe_q <= 1'b1;
        end
        START: if (tick) begin
          state_q <= DATA;
          idx_q <= '0;
          tx_out_q <= sh_q[0];
        end
        DATA: if (tick) begin
          if (idx_q == 3'd7) begin
            state_q <= PARITY;
            tx_out_q <= par_q;
          end else begin
            idx_q <= idx_q + 3'd1;
            sh_q <= sh_q >> 1;
            tx_out_q <= sh_q[1];
          end
        end
        PARITY: if (tick) begin
          state_q <= STOP;
          idx_q <= '0;
          tx_out_q <= 1'b1;
        end
        STOP: if (tick) begin
          if (idx_q == 3'd1) begin
            tx_oe_q <= 1'b0;
`ifdef UPDI_TX_IDLE_GAP_EN
            state_q <= GAP;
            gap_q <= '0;
`else
            state_q <= IDLE;
`endif
          end else idx_q <= 3'd1;
        end
`ifdef UPDI_TX_IDLE_GAP_EN
        GAP: if (tick) begin
          if (gap_q == GAP_LAST) state_q <= IDLE;
          else gap_q <= gap_q + 4'd1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_updi_uart_tx.sv
// tb_updi_uart_tx: directed checks of UPDI frame timing, parity, gating, back-to-back and reset
module tb_updi_uart_tx;
  localparam int DIV = 4;
`ifdef UPDI_TX_IDLE_GAP_EN
  localparam int FLEN = 56;
`else
  localparam int FLEN = 48;
`endif
  logic clk = 0, rst = 1, tx_enable = 0;
  logic tx_out, tx_oe, busy, frame_done;
  logic [7:0] mem [16];
  int wp = 0, rp = 0, pops = 0, cyc = 0, tests = 0, fails = 0;
  updi_uart_tx_if bus();
  updi_uart_tx #(.UART_CLK_DIV(DIV), .IDLE_GAP_BITS(2)) dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo(bus.master),
    .tx_out(tx_out), .tx_oe(tx_oe), .busy(busy), .frame_done(frame_done));
  always #5 clk = ~clk;
  assign bus.fifo_data = mem[rp[3:0]];
  assign bus.fifo_empty = (wp == rp);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en) begin
      pops <= pops + 1;
      rp <= rp + 1;
      if (bus.fifo_empty) begin
        fails++;
        $display("FAIL pop_when_empty: rd_en=1 empty=1 required no pop");
      end
    end
  end
  task automatic push(input logic [7:0] d);
    mem[wp[3:0]] = d;
    wp = wp + 1;
  endtask
  task automatic wait_pop();
    #1;
    for (int k = 0; k < 200; k++) begin
      if (bus.fifo_rd_en) break;
      @(negedge clk);
      #1;
    end
    tests++;
    if (bus.fifo_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL pop_timeout: rd_en=%b required 1", bus.fifo_rd_en);
    end
  endtask
  task automatic capture_frame(input logic [7:0] b, input int drop, output logic pbit);
    logic bad = 0, ex;
    int first = 0, k;
    logic fo = 0, foe = 0, fd = 0;
    pbit = 1'bx;
    for (int i = 1; i <= FLEN; i++) begin
      @(negedge clk);
      if (i == drop) tx_enable = 0;
      k = (i - 1) / DIV;
      ex = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : (k == 9) ? ^b : 1'b1;
      if (k == 9) pbit = tx_out;
      if (!bad && (tx_out !== ex || tx_oe !== (k < 12) || busy !== 1'b1 || frame_done !== (i == FLEN))) begin
        bad = 1;
        first = i;
        fo = tx_out;
        foe = tx_oe;
        fd = frame_done;
      end
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL frame_%h: cycle %0d got out=%b oe=%b done=%b", b, first, fo, foe, fd);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    tests += 5;
    if (tx_out !== 1'b1) begin fails++; $display("FAIL rst_tx_out: got %b required 1", tx_out); end
    if (tx_oe !== 1'b0) begin fails++; $display("FAIL rst_tx_oe: got %b required 0", tx_oe); end
    if (bus.fifo_rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en: got %b required 0", bus.fifo_rd_en); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b required 0", frame_done); end
    rst = 0;
    tx_enable = 1;
    repeat (5) @(negedge clk);
    tests += 2;
    if (pops != 0) begin fails++; $display("FAIL empty_hold_pops: got %0d required 0", pops); end
    if (tx_out !== 1'b1 || tx_oe !== 1'b0) begin fails++; $display("FAIL empty_hold_line: out=%b oe=%b required 1/0", tx_out, tx_oe); end
  endtask
  task automatic test_single();
    logic p;
    int p0;
    push(8'h55);
    wait_pop();
    p0 = pops;
    capture_frame(8'h55, 0, p);
    @(negedge clk);
    tests += 2;
    if (pops != p0 + 1) begin fails++; $display("FAIL single_pops: got %0d required %0d", pops, p0 + 1); end
    if (tx_out !== 1'b1 || tx_oe !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: out=%b oe=%b busy=%b required 1/0/0", tx_out, tx_oe, busy);
    end
  endtask
  task automatic test_parity();
    logic p;
    push(8'h01);
    wait_pop();
    capture_frame(8'h01, 0, p);
    tests++;
    if (p !== 1'b1) begin fails++; $display("FAIL parity_01: got %b required 1", p); end
    push(8'hFF);
    wait_pop();
    capture_frame(8'hFF, 0, p);
    tests++;
    if (p !== 1'b0) begin fails++; $display("FAIL parity_ff: got %b required 0", p); end
  endtask
  task automatic test_back_to_back();
    logic p;
    int c0;
    push(8'hA5);
    push(8'h3C);
    wait_pop();
    c0 = cyc;
    capture_frame(8'hA5, 0, p);
    @(negedge clk);
    #1;
    tests += 3;
    if (tx_out !== 1'b1 || tx_oe !== 1'b0) begin fails++; $display("FAIL b2b_idle: out=%b oe=%b required 1/0", tx_out, tx_oe); end
    if (bus.fifo_rd_en !== 1'b1) begin fails++; $display("FAIL b2b_pop: rd_en=%b required 1", bus.fifo_rd_en); end
    if (cyc - c0 != FLEN + 1) begin fails++; $display("FAIL b2b_spacing: got %0d required %0d", cyc - c0, FLEN + 1); end
    capture_frame(8'h3C, 0, p);
  endtask
  task automatic test_gating();
    logic p;
    int p0;
    @(negedge clk);
    tx_enable = 0;
    push(8'h12);
    p0 = pops;
    repeat (20) @(negedge clk);
    tests++;
    if (pops != p0 || busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL gate_hold: pops=%0d busy=%b rd_en=%b required %0d/0/0", pops, busy, bus.fifo_rd_en, p0);
    end
    tx_enable = 1;
    #1;
    tests++;
    if (bus.fifo_rd_en !== 1'b1) begin fails++; $display("FAIL gate_release: rd_en=%b required 1", bus.fifo_rd_en); end
    capture_frame(8'h12, 20, p);
    @(negedge clk);
    tests++;
    if (pops != p0 + 1) begin fails++; $display("FAIL gate_pops: got %0d required %0d", pops, p0 + 1); end
    tx_enable = 1;
  endtask
  task automatic test_reset_mid_frame();
    logic p;
    push(8'h77);
    push(8'h88);
    wait_pop();
    repeat (18) @(negedge clk);
    rst = 1;
    @(negedge clk);
    tests += 3;
    if (tx_out !== 1'b1 || tx_oe !== 1'b0) begin fails++; $display("FAIL midrst_line: out=%b oe=%b required 1/0", tx_out, tx_oe); end
    if (busy !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL midrst_status: busy=%b done=%b required 0/0", busy, frame_done); end
    if (wp - rp != 1) begin fails++; $display("FAIL midrst_depth: got %0d required 1", wp - rp); end
    @(negedge clk);
    rst = 0;
    wait_pop();
    capture_frame(8'h88, 0, p);
  endtask
  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_gating();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/updi_uart_tx.md
# updi_uart_tx

UPDI transmit serializer that sits in `updi_phy` directly downstream of the UART TX FIFO, which `updi_interface` fills. It pops one byte at a time and drives it onto the single-wire UPDI line using the UPDI frame format: 1 start bit, 8 data bits LSB first, even parity, 2 stop bits. It also drives a line-drive enable, so the PHY can release the half-duplex pin to the target between frames.

## Interface
- `UART_CLK_DIV`, default 10: `clk` cycles per bit-time; legal range ≥ 2.
- `IDLE_GAP_BITS`, default 2: idle bit-times inserted after each frame; used only when `UPDI_TX_IDLE_GAP_EN` is defined; legal range 1–15.
- `clk`  in  1: system clock.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `tx_enable`  in  1: PHY permits a new frame to start; low while a double break or RX is in progress.
- `fifo_data`  in  8: head of TX FIFO; valid whenever `fifo_empty` is 0.
- `fifo_empty`  in  1: TX FIFO empty flag.
- `fifo_rd_en`  out  1: one-cycle pop strobe.
- `tx_out`  out  1: serial line value; 1 = idle/mark.
- `tx_oe`  out  1: line drive enable; 1 = block drives `tx_out` onto the pin.
- `busy`  out  1: frame in progress, or a pop has just been issued.
- `frame_done`  out  1: one-cycle pulse when the last stop bit (or gap, if enabled) completes.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PARITY
  - STOP
  - GAP (exists only when `UPDI_TX_IDLE_GAP_EN` is defined).
- IDLE:
  - When `tx_enable` = 1 and `fifo_empty` = 0: assert `fifo_rd_en` for exactly that cycle.
  - In the same cycle, latch `fifo_data` into the shift register, compute parity = XOR of the 8 bits, and go to START.
  - Otherwise stay in IDLE.
- START: `tx_out` = 0 for one bit-time.
- DATA: shift out bit 0 first; a 3-bit index counts 0..7; 8 bit-times in total.
- PARITY: `tx_out` = latched even parity for one bit-time.
- STOP:
  - `tx_out` = 1 for two bit-times.
  - Then go to GAP if the macro is enabled; otherwise pulse `frame_done` and return to IDLE.
- GAP:
  - `tx_out` = 1 and `tx_oe` = 0 for `IDLE_GAP_BITS` bit-times.
  - Then pulse `frame_done` and return to IDLE.
- Output values:
  - `tx_oe` = 1 in START, DATA, PARITY and STOP; 0 in IDLE and GAP.
  - `tx_out` = 1 in IDLE.
- `busy` = 1 in every state except IDLE, and also in the IDLE cycle that pops.
- `tx_enable` is sampled only in IDLE. Deasserting it mid-frame does not abort the frame; the frame completes.
- Bit-time counter:
  - Width $clog2(UART_CLK_DIV); counts 0..UART_CLK_DIV-1.
  - A state/bit advances when the counter reaches UART_CLK_DIV-1.
  - The counter clears on every state entry.

## Timing
- Reset values:
  - `tx_out` = 1, `tx_oe` = 0, `fifo_rd_en` = 0, `busy` = 0, `frame_done` = 0.
  - State = IDLE; counters and shift register = 0.
- Reset mid-frame: on the next edge the line returns to idle (`tx_out` = 1, `tx_oe` = 0). The partially sent byte is dropped and is not re-read.
- Start latency: the pop cycle is N. The start bit is driven from cycle N+1.
- Frame length, without the macro: 12 × UART_CLK_DIV cycles from the first start-bit cycle through the last stop-bit cycle.
- `frame_done` is high in the final cycle of the last stop bit (or of the last gap bit).
- Back-to-back frames: the frame-done cycle leads into IDLE in cycle M+1, which may pop immediately. This leaves exactly one `clk` of idle (`tx_out` = 1, `tx_oe` = 0) between frames.
- FIFO empty in IDLE: no pop and no output change. The block holds until data arrives.
- `fifo_rd_en` is never asserted when `fifo_empty` = 1.

## Configuration
- `UPDI_TX_IDLE_GAP_EN`:
  - Defined: the GAP state is compiled in. Each frame ends with `IDLE_GAP_BITS` released bit-times before `frame_done`, which satisfies the target's inter-byte guard requirement.
  - Undefined: GAP and its counter are absent, `IDLE_GAP_BITS` is ignored, and `frame_done` fires at the end of the second stop bit.

## Test plan
- Single byte, UART_CLK_DIV=4, macro off:
  - Stimulus: push 0x55 with `tx_enable` = 1.
  - Response: one pop.
    - Line over 48 cycles, 4 cycles per bit: 0, then data 1,0,1,0,1,0,1,0, then parity 0, then stop 1,1.
    - `tx_oe` = 1 for those 48 cycles.
    - `frame_done` pulses on cycle 48.
- Parity check:
  - Stimulus: byte 0x01.
  - Response: parity bit 1. Byte 0xFF gives parity 0.
- Back-to-back:
  - Stimulus: push 0xA5 and 0x3C.
  - Response: two pops 49 cycles apart (DIV=4), with exactly one idle `clk` between the last stop bit and the next start bit.
- Gating:
  - Stimulus: FIFO holds 0x12 and `tx_enable` = 0 for 20 cycles, then goes to 1.
  - Response: no pop while gated; pop on the first cycle `tx_enable` = 1. Dropping `tx_enable` during DATA still completes the frame.
- Reset mid-frame:
  - Stimulus: assert `rst` during DATA bit 3.
  - Response: next cycle `tx_out` = 1, `tx_oe` = 0, `busy` = 0, no `frame_done`; FIFO depth is unchanged afterwards.
- Macro on, IDLE_GAP_BITS=2, DIV=4:
  - Stimulus: push one byte.
  - Response: `frame_done` at cycle 56, preceded by 8 cycles with `tx_oe` = 0 and `tx_out` = 1.
